// File: rtl/sobel_pkg.sv
// Shared constants for the streaming Sobel engine: FSM encodings, default
// sizes, saturation limit and coordinate-width helpers.
// Optional build macro used by the top: SOBEL_STREAM_DIR_EN.
package sobel_pkg;

  localparam int DEF_WORD_SIZE    = 8;
  localparam int DEF_FRAME_WIDTH  = 640;
  localparam int DEF_FRAME_HEIGHT = 480;
  localparam int DEF_THRESHOLD    = 50;
  localparam int DEF_MAX          = (1 << DEF_WORD_SIZE) - 1;
  localparam int DIR_W            = 2;

  // Frame FSM encodings (IDLE / ACTIVE / DONE)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Largest representable magnitude for a given word size
  function automatic int sat_max(input int word_size);
    return (1 << word_size) - 1;
  endfunction

  // Bits needed to hold a coordinate in 0..n-1 (n >= 3)
  function automatic int coord_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel kernel. Window taps are win_i[0..8] = p1..p9,
// rows top to bottom, columns left to right. Produces the saturated
// |dx|+|dy| magnitude plus the raw absolute gradients and their signs.
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic [WORD_SIZE-1:0] win_i [9],
  output logic [WORD_SIZE-1:0] mag_o,
  output logic [WORD_SIZE+2:0] abs_dx_o,
  output logic [WORD_SIZE+2:0] abs_dy_o,
  output logic                 dx_neg_o,
  output logic                 dy_neg_o
);

  localparam int SW = WORD_SIZE + 3;
  localparam int MW = WORD_SIZE + 4;
  localparam logic [WORD_SIZE-1:0] MAX = WORD_SIZE'(sat_max(WORD_SIZE));

  logic signed [SW-1:0] s [9];
  logic signed [SW-1:0] dx;
  logic signed [SW-1:0] dy;
  logic [MW-1:0]        sum;
  logic [WORD_SIZE-1:0] centre_unused;

  // Zero-extend every tap into the signed gradient width
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      s[i] = signed'({3'b000, win_i[i]});
    end
  end

  // The centre tap carries zero weight in both gradients
  assign centre_unused = win_i[4];

  // dx: left column minus right column; dy: top row minus bottom row
  assign dx = (s[0] + (s[3] <<< 1) + s[6]) - (s[2] + (s[5] <<< 1) + s[8]);
  assign dy = (s[0] + (s[1] <<< 1) + s[2]) - (s[6] + (s[7] <<< 1) + s[8]);

  assign dx_neg_o = dx[SW-1];
  assign dy_neg_o = dy[SW-1];
  assign abs_dx_o = dx_neg_o ? unsigned'(-dx) : unsigned'(dx);
  assign abs_dy_o = dy_neg_o ? unsigned'(-dy) : unsigned'(dy);

  assign sum   = {1'b0, abs_dx_o} + {1'b0, abs_dy_o};
  assign mag_o = (|sum[MW-1:WORD_SIZE]) ? MAX : sum[WORD_SIZE-1:0];

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge engine. Two full-row line buffers plus a
// two-column window history build the 3x3 window on every accepted pixel;
// interior centres are emitted one cycle after the completing accept, with
// out_sof on centre (1,1) and out_eol on the last interior column.
// Handshake: a pixel is accepted when in_valid is high and the FSM is
// ACTIVE, or when in_valid & in_sof (which always restarts at (0,0));
// there is no backpressure and in_valid=0 cycles freeze all state.
// Optional macro SOBEL_STREAM_DIR_EN adds the 2-bit out_dir port.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int FRAME_WIDTH   = DEF_FRAME_WIDTH,
  parameter int FRAME_HEIGHT  = DEF_FRAME_HEIGHT,
  parameter int THRESHOLD_RST = DEF_THRESHOLD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 thr_load,
  input  logic [WORD_SIZE-1:0] thr_value,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out_mag,
  output logic                 out_edge,
  output logic                 out_sof,
  output logic                 out_eol
`ifdef SOBEL_STREAM_DIR_EN
  ,
  output logic [DIR_W-1:0]     out_dir
`endif
);

  localparam int XW = coord_w(FRAME_WIDTH);
  localparam int YW = coord_w(FRAME_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);
  localparam logic [WORD_SIZE-1:0] THR_RST = WORD_SIZE'(THRESHOLD_RST);

  logic [1:0]           state_q, state_d;
  logic [XW-1:0]        x_q, x_d, x_cur;
  logic [YW-1:0]        y_q, y_d, y_cur;
  logic [WORD_SIZE-1:0] thr_q, thr_d, thr_eff;

  logic                 accept, emit, last_px;
  logic [WORD_SIZE-1:0] top_px, mid_px;

  // Row y-1 and row y-2 storage, indexed by column
  logic [WORD_SIZE-1:0] lb1_q [FRAME_WIDTH];
  logic [WORD_SIZE-1:0] lb2_q [FRAME_WIDTH];
  // Window history: col1 = column x-1, col2 = column x-2 (top, mid, bottom)
  logic [WORD_SIZE-1:0] col1_q [3];
  logic [WORD_SIZE-1:0] col2_q [3];
  logic [WORD_SIZE-1:0] win [9];

  logic [WORD_SIZE-1:0] k_mag;
  logic [WORD_SIZE+2:0] k_abs_dx, k_abs_dy;
  logic                 k_dx_neg, k_dy_neg;

  logic                 out_valid_q, out_valid_d;
  logic [WORD_SIZE-1:0] out_mag_q, out_mag_d;
  logic                 out_edge_q, out_edge_d;
  logic                 out_sof_q, out_sof_d;
  logic                 out_eol_q, out_eol_d;

  // A start-of-frame beat always restarts the raster at (0,0)
  assign accept  = in_valid & (in_sof | (state_q == ST_ACTIVE));
  assign x_cur   = in_sof ? '0 : x_q;
  assign y_cur   = in_sof ? '0 : y_q;
  assign top_px  = lb2_q[x_cur];
  assign mid_px  = lb1_q[x_cur];
  assign last_px = (x_cur == X_LAST) && (y_cur == Y_LAST);
  assign emit    = accept && (x_cur >= X_TWO) && (y_cur >= Y_TWO);
  // A load in the same cycle already governs the beat registered now
  assign thr_eff = thr_load ? thr_value : thr_q;
  assign thr_d   = thr_eff;

  // Assemble p1..p9 from history columns and the current column
  always_comb begin
    win[0] = col2_q[0];
    win[1] = col1_q[0];
    win[2] = top_px;
    win[3] = col2_q[1];
    win[4] = col1_q[1];
    win[5] = mid_px;
    win[6] = col2_q[2];
    win[7] = col1_q[2];
    win[8] = in_data;
  end

  sobel_kernel #(
    .WORD_SIZE(WORD_SIZE)
  ) u_kernel (
    .win_i   (win),
    .mag_o   (k_mag),
    .abs_dx_o(k_abs_dx),
    .abs_dy_o(k_abs_dy),
    .dx_neg_o(k_dx_neg),
    .dy_neg_o(k_dy_neg)
  );

  // Frame FSM and raster counters; advance only on accepted pixels
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (accept) begin
      if (last_px) begin
        state_d = ST_DONE;
        x_d     = '0;
        y_d     = '0;
      end else begin
        state_d = ST_ACTIVE;
        if (x_cur == X_LAST) begin
          x_d = '0;
          y_d = y_cur + 1'b1;
        end else begin
          x_d = x_cur + 1'b1;
          y_d = y_cur;
        end
      end
    end
  end

  // Output beat for the centre (x-1,y-1); all fields zero when not emitting
  always_comb begin
    out_valid_d = emit;
    out_mag_d   = emit ? k_mag : '0;
    out_edge_d  = emit && (k_mag > thr_eff);
    out_sof_d   = emit && (x_cur == X_TWO) && (y_cur == Y_TWO);
    out_eol_d   = emit && (x_cur == X_LAST);
  end

  // Control, threshold and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      thr_q       <= THR_RST;
      out_valid_q <= 1'b0;
      out_mag_q   <= '0;
      out_edge_q  <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      thr_q       <= thr_d;
      out_valid_q <= out_valid_d;
      out_mag_q   <= out_mag_d;
      out_edge_q  <= out_edge_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
    end
  end

  // Line buffers and window history; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2_q[x_cur] <= mid_px;
      lb1_q[x_cur] <= in_data;
      col2_q       <= col1_q;
      col1_q       <= '{top_px, mid_px, in_data};
    end
  end

  assign out_valid = out_valid_q;
  assign out_mag   = out_mag_q;
  assign out_edge  = out_edge_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;

`ifdef SOBEL_STREAM_DIR_EN
  logic [DIR_W-1:0] out_dir_q, out_dir_d;
  logic             dy_dom;

  // bit1: vertical gradient dominates; bit0: dominant component negative
  always_comb begin
    dy_dom    = k_abs_dy > k_abs_dx;
    out_dir_d = '0;
    if (emit) begin
      out_dir_d = {dy_dom, dy_dom ? k_dy_neg : k_dx_neg};
    end
  end

  // Direction register, aligned with out_mag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_dir_q <= '0;
    end else begin
      out_dir_q <= out_dir_d;
    end
  end

  assign out_dir = out_dir_q;
`else
  // Gradient detail is only consumed by the direction output
  logic [2*(WORD_SIZE+3)+1:0] kernel_unused;
  assign kernel_unused = {k_abs_dx, k_abs_dy, k_dx_neg, k_dy_neg};
`endif

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream at FRAME_WIDTH=8, FRAME_HEIGHT=6.
// Expected magnitudes come from hand-computed per-column tables for each
// test image (flat, 0/255 step at column 4, 0/10 step at column 4).
module tb_sobel_stream;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_data;
  logic       thr_load;
  logic [7:0] thr_value;
  logic       out_valid;
  logic [7:0] out_mag;
  logic       out_edge;
  logic       out_sof;
  logic       out_eol;
  logic [1:0] out_dir;

  int checks_total  = 0;
  int checks_passed = 0;
  int beat_cnt      = 0;
  int eol_cnt       = 0;
  int sof_cnt       = 0;
  int thr_model     = 50;
  logic [7:0] exp_q[$];

  sobel_stream #(
    .WORD_SIZE    (8),
    .FRAME_WIDTH  (8),
    .FRAME_HEIGHT (6),
    .THRESHOLD_RST(50)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_data  (in_data),
    .thr_load (thr_load),
    .thr_value(thr_value),
    .out_valid(out_valid),
    .out_mag  (out_mag),
    .out_edge (out_edge),
    .out_sof  (out_sof),
`ifdef SOBEL_STREAM_DIR_EN
    .out_eol  (out_eol),
    .out_dir  (out_dir)
`else
    .out_eol  (out_eol)
`endif
  );

`ifndef SOBEL_STREAM_DIR_EN
  assign out_dir = 2'b00;
`endif

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    assert (got === exp) checks_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Test images: 0 flat 100, 1 step 0->255 at col 4, 2 step 0->10 at col 4
  function automatic logic [7:0] pix(input int kind, input int x);
    case (kind)
      1:       return (x >= 4) ? 8'd255 : 8'd0;
      2:       return (x >= 4) ? 8'd10 : 8'd0;
      default: return 8'd100;
    endcase
  endfunction

  // Hand-computed magnitude per centre column
  function automatic logic [7:0] exp_mag(input int kind, input int cx);
    if (kind == 1 && (cx == 3 || cx == 4)) return 8'd255;
    if (kind == 2 && (cx == 3 || cx == 4)) return 8'd40;
    return 8'd0;
  endfunction

  // Step edges have a dominant negative dx
  function automatic logic [1:0] exp_dir(input int kind, input int cx);
    if (kind != 0 && (cx == 3 || cx == 4)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_outputs(input logic exp_v, input logic exp_s,
                               input logic exp_e, input logic [1:0] exp_d);
    logic [7:0] m;
    m = 8'd0;
    if (exp_q.size() != 0) m = exp_q.pop_front();
    check("valid", out_valid, exp_v);
    check("mag", out_mag, m);
    check("edge", out_edge, (exp_v && (m > thr_model)) ? 1 : 0);
    check("sof", out_sof, exp_s);
    check("eol", out_eol, exp_e);
`ifdef SOBEL_STREAM_DIR_EN
    check("dir", out_dir, exp_d);
`endif
    if (out_valid === 1'b1) beat_cnt++;
    if (out_eol === 1'b1) eol_cnt++;
    if (out_sof === 1'b1) sof_cnt++;
  endtask

  task automatic drive_pixel(input logic [7:0] d, input logic sof, input logic exp_v,
                             input logic [7:0] m, input logic exp_s, input logic exp_e,
                             input logic [1:0] exp_d);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    if (exp_v) exp_q.push_back(m);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check_outputs(exp_v, exp_s, exp_e, exp_d);
  endtask

  // A gap cycle with junk data and a stray sof: must not disturb anything
  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'($urandom_range(0, 1));
    in_data  = 8'($urandom_range(0, 255));
    @(posedge clk);
    #1;
    in_sof = 1'b0;
    check_outputs(1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic load_thr(input logic [7:0] v);
    @(negedge clk);
    thr_load  = 1'b1;
    thr_value = v;
    @(posedge clk);
    #1;
    thr_load  = 1'b0;
    thr_model = v;
  endtask

  task automatic send_frame(input int kind, input int npix, input bit first_sof,
                            input bit live, input bit gaps);
    beat_cnt = 0;
    eol_cnt  = 0;
    sof_cnt  = 0;
    for (int i = 0; i < npix; i++) begin
      int   x;
      int   y;
      logic v;
      x = i % 8;
      y = i / 8;
      if (gaps && ($urandom_range(0, 1) == 1)) idle_cycle();
      v = live && (x >= 2) && (y >= 2);
      drive_pixel(pix(kind, x), first_sof && (i == 0), v, exp_mag(kind, x - 1),
                  v && (x == 2) && (y == 2), v && (x == 7),
                  v ? exp_dir(kind, x - 1) : 2'b00);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = 8'd0;
    thr_load  = 1'b0;
    thr_value = 8'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs(1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    reset = 1'b0;

    // Flat frame, continuous valid
    send_frame(0, 48, 1, 1, 0);
    check("flat_beats", beat_cnt, 24);
    check("flat_eols", eol_cnt, 4);
    check("flat_sofs", sof_cnt, 1);

    // 0/255 step: saturated edges on centre cols 3 and 4
    send_frame(1, 48, 1, 1, 0);
    check("step255_beats", beat_cnt, 24);

    // 0/10 step: mag 40, below threshold 50
    load_thr(8'd50);
    send_frame(2, 48, 1, 1, 0);
    check("step10_beats", beat_cnt, 24);

    // Same image, threshold 39: strictly greater, so edges flagged
    load_thr(8'd39);
    send_frame(2, 48, 1, 1, 0);
    check("step10_t39_beats", beat_cnt, 24);

    // Flat frame with random gaps
    send_frame(0, 48, 1, 1, 1);
    check("gap_beats", beat_cnt, 24);
    check("gap_eols", eol_cnt, 4);

    // Abort after 20 pixels; new frame restarts at the sof pixel
    send_frame(2, 20, 1, 1, 0);
    check("abort_old_beats", beat_cnt, 2);
    send_frame(1, 48, 1, 1, 0);
    check("abort_new_beats", beat_cnt, 24);
    check("abort_new_eols", eol_cnt, 4);

    // DONE: pixels without sof are dropped
    send_frame(0, 60, 0, 0, 0);
    check("done_drop_beats", beat_cnt, 0);

    // Asynchronous reset mid-frame, with a non-default threshold loaded
    load_thr(8'd39);
    send_frame(1, 30, 1, 1, 0);
    check("pre_reset_mag", out_mag, 255);
    #2;
    reset = 1'b1;
    #1;
    thr_model = 50;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_mag", out_mag, 0);
    check("async_rst_edge", out_edge, 0);
    check("async_rst_eol", out_eol, 0);
    check("async_rst_dir", out_dir, 0);
    @(negedge clk);
    reset = 1'b0;
    send_frame(2, 10, 0, 0, 0);
    check("post_rst_ignored", beat_cnt, 0);
    // Threshold back to 50, so mag 40 is not an edge
    send_frame(2, 48, 1, 1, 0);
    check("post_rst_beats", beat_cnt, 24);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
Name: sobel_stream

Overview:
- Streaming 3x3 Sobel edge engine with internal line buffers, pixel-valid handshake and frame/line framing.
- Successor to the fixed-width Sobel path: frame size, word size and threshold are parametrised, threshold is also runtime-programmable, and magnitude arithmetic is widened and saturated.
- Sits between intensity conversion and connected-components labelling; emits only interior pixels, with framing markers.

Parameters:
WORD_SIZE, 8, pixel/intensity width in bits
FRAME_WIDTH, 640, pixels per row (>=3)
FRAME_HEIGHT, 480, rows per frame (>=3)
THRESHOLD_RST, 50, threshold used when thr_load never asserted since reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  in_data/in_sof valid this cycle
in_sof  in  1  qualifies first pixel of a frame (x=0,y=0)
in_data  in  WORD_SIZE  intensity pixel, raster order
thr_load  in  1  load thr_value into threshold register
thr_value  in  WORD_SIZE  new threshold
out_valid  out  1  output beat valid
out_mag  out  WORD_SIZE  saturated |dx|+|dy|
out_edge  out  1  out_mag > threshold
out_sof  out  1  first interior pixel of frame
out_eol  out  1  last interior pixel of a row

Behaviour:
- Clock and reset: one clock `clk`; `reset` is asynchronous and active-high.
- Reset values: all outputs 0; x=y=0; state=IDLE; threshold=THRESHOLD_RST. Line-buffer contents are don't-care.
- FSM transitions:
  - IDLE -> ACTIVE on in_valid & in_sof.
  - ACTIVE -> DONE after pixel (FRAME_WIDTH-1, FRAME_HEIGHT-1) is accepted.
  - DONE -> ACTIVE on in_valid & in_sof.
  - In IDLE and DONE, pixels without in_sof are dropped.
- Pixel acceptance and counters:
  - Every in_valid beat in ACTIVE is accepted; there is no backpressure.
  - Gaps (in_valid=0) freeze all state.
  - x increments per accepted pixel and wraps at FRAME_WIDTH-1, incrementing y.
- in_sof while ACTIVE (mid-frame):
  - Abort the current frame; that pixel becomes (0,0) of the new frame.
  - No further outputs are produced from the aborted frame.
- Line buffers: two FRAME_WIDTH-deep rows plus a 3-tap current-row shift register, advanced only on accepted pixels.
- Window and output mapping:
  - Window rows map top to bottom as y-2, y-1, y; window cols as x-2, x-1, x.
  - When accepted pixel (x,y) has x>=2 and y>=2, one output for centre (x-1,y-1) is registered.
  - out_valid rises the cycle after that accept (latency 1).
  - Frame yields exactly (FRAME_WIDTH-2)*(FRAME_HEIGHT-2) outputs.
- Framing markers:
  - out_sof with centre (1,1).
  - out_eol with centre x=FRAME_WIDTH-2.
- Arithmetic:
  - dx = (p1+2p4+p7)-(p3+2p6+p9); dy = (p1+2p2+p3)-(p7+2p8+p9).
  - Both computed signed at WORD_SIZE+3 bits; abs values summed at WORD_SIZE+4 bits.
  - Sum saturates to 2^WORD_SIZE-1.
- Threshold: thr_load takes effect on the next output beat; applies while a frame is in flight. Edge test is strict greater-than.
- out_valid low: out_mag, out_edge, out_sof and out_eol hold 0.

Optional Feature:
- Macro SOBEL_STREAM_DIR_EN defined: adds port out_dir (out, 2 bits), registered alongside out_mag.
  - bit1 = (|dy| > |dx|).
  - bit0 = sign of the dominant component (dy if bit1, else dx), 1 = negative.
  - 0 when out_valid=0.
- Macro undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package sobel_pkg: state enum {IDLE, ACTIVE, DONE}; WORD_SIZE default; MAX for saturation; coordinate width via clog2(FRAME_WIDTH), clog2(FRAME_HEIGHT); DIR_W=2.
- One combinational sub-module sobel_kernel: nine WORD_SIZE inputs, outputs saturated magnitude, raw abs_dx/abs_dy, sign bits.
- Line buffers and FSM stay in sobel_stream.

Test Plan:
- W=8,H=6, flat frame all 100, continuous valid -> 24 beats of mag=0, edge=0; out_sof on beat 1; out_eol on beats 6,12,18,24.
- Same size, cols 0-3=0, cols 4-7=255 -> interior cols 3 and 4 give mag=255 (|dx|=1020 saturated), edge=1; other cols mag=0.
- Step 0->10 at col 4, thr_load 50 -> col 3,4 mag=40, edge=0. Repeat with thr_load 39 -> edge=1.
- Flat frame with in_valid random 50% duty -> output sequence identical to continuous case; each out_valid one cycle after the completing accept.
- in_sof re-asserted at pixel 20 (ACTIVE) -> no more outputs of old frame; full 24 beats for new frame. 60 extra pixels without sof in DONE -> no outputs.
- reset pulsed asynchronously mid-frame -> outputs 0 immediately, threshold=50; pixels ignored until next in_sof. With SOBEL_STREAM_DIR_EN, step test gives out_dir=2'b01 on edge columns.
